// File: rtl/cnn_pkg.sv
// Shared constants and pixel type for the conv1 -> pool -> conv2 path.
package cnn_pkg;
    localparam int CONV1_OUT_BIT = 12;
    localparam int CONV1_MAP     = 24;
    localparam int POOL1_MAP     = 12;
    localparam int CONV1_CH      = 3;

    typedef logic signed [CONV1_OUT_BIT-1:0] conv1_pix_t;
endpackage

// File: rtl/maxpool_relu_lane.sv
// One channel of 2x2 stride-2 max pooling followed by ReLU.
module maxpool_relu_lane
    import cnn_pkg::*;
#(
    parameter int CONV_BIT = CONV1_OUT_BIT,
    parameter int HALF     = POOL1_MAP,
    parameter int IDX_BIT  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_i,
    input  logic                       col_odd_i,
    input  logic                       row_odd_i,
    input  logic [IDX_BIT-1:0]         idx_i,
    input  logic signed [CONV_BIT-1:0] pix_i,
    output logic signed [CONV_BIT-1:0] pool_o
);
    logic signed [CONV_BIT-1:0] left_q;
    logic signed [CONV_BIT-1:0] pool_q, pool_d;
    logic signed [CONV_BIT-1:0] pair, quad;
    logic signed [CONV_BIT-1:0] half_q [HALF];

    always_comb begin
        pair   = (pix_i > left_q) ? pix_i : left_q;
        quad   = (half_q[idx_i] > pair) ? half_q[idx_i] : pair;
        pool_d = pool_q;
        if (valid_i && col_odd_i && row_odd_i) begin
            pool_d = quad[CONV_BIT-1] ? '0 : quad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            left_q <= '0;
            pool_q <= '0;
        end else begin
            if (valid_i && !col_odd_i) begin
                left_q <= pix_i;
            end
            pool_q <= pool_d;
        end
    end

    // Every entry is rewritten in an even row before its odd-row read.
    always_ff @(posedge clk) begin
        if (!rst && valid_i && col_odd_i && !row_odd_i) begin
            half_q[idx_i] <= pair;
        end
    end

    assign pool_o = pool_q;
endmodule

// File: rtl/conv1_maxpool_relu.sv
// Raster counters and output strobes shared by three pooling lanes.
module conv1_maxpool_relu
    import cnn_pkg::*;
#(
    parameter int CONV_BIT  = CONV1_OUT_BIT,
    parameter int IN_WIDTH  = CONV1_MAP,
    parameter int IN_HEIGHT = CONV1_MAP,
    parameter int COL_BIT   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic signed [CONV_BIT-1:0] conv_in_1,
    input  logic signed [CONV_BIT-1:0] conv_in_2,
    input  logic signed [CONV_BIT-1:0] conv_in_3,
    output logic signed [CONV_BIT-1:0] pool_out_1,
    output logic signed [CONV_BIT-1:0] pool_out_2,
    output logic signed [CONV_BIT-1:0] pool_out_3,
    output logic                       valid_out_relu,
    output logic                       frame_done
);
    logic [COL_BIT-1:0] col_q, col_d;
    logic [COL_BIT-1:0] row_q, row_d;
    logic               col_last, row_last;
    logic               vout_q, done_q;
    logic signed [CONV_BIT-1:0] pix  [CONV1_CH];
    logic signed [CONV_BIT-1:0] pool [CONV1_CH];

    assign col_last = (col_q == COL_BIT'(IN_WIDTH - 1));
    assign row_last = (row_q == COL_BIT'(IN_HEIGHT - 1));

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (valid_in) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + COL_BIT'(1);
            end else begin
                col_d = col_q + COL_BIT'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            vout_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            vout_q <= valid_in && col_q[0] && row_q[0];
            done_q <= valid_in && col_last && row_last;
        end
    end

    assign pix[0] = conv_in_1;
    assign pix[1] = conv_in_2;
    assign pix[2] = conv_in_3;

    for (genvar g = 0; g < CONV1_CH; g++) begin : g_lane
        maxpool_relu_lane #(
            .CONV_BIT (CONV_BIT),
            .HALF     (IN_WIDTH / 2),
            .IDX_BIT  (COL_BIT - 1)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .valid_i   (valid_in),
            .col_odd_i (col_q[0]),
            .row_odd_i (row_q[0]),
            .idx_i     (col_q[COL_BIT-1:1]),
            .pix_i     (pix[g]),
            .pool_o    (pool[g])
        );
    end

    assign pool_out_1     = pool[0];
    assign pool_out_2     = pool[1];
    assign pool_out_3     = pool[2];
    assign valid_out_relu = vout_q;
    assign frame_done     = done_q;
endmodule

// File: tb/tb_conv1_maxpool_relu.sv
// Directed/random bench for conv1_maxpool_relu against a window-level model.
module tb_conv1_maxpool_relu;
    import cnn_pkg::*;

    localparam int N = CONV1_MAP * CONV1_MAP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    conv1_pix_t conv_in_1 = '0;
    conv1_pix_t conv_in_2 = '0;
    conv1_pix_t conv_in_3 = '0;
    conv1_pix_t pool_out_1, pool_out_2, pool_out_3;
    logic       valid_out_relu, frame_done;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int acc_cyc = -1;

    conv1_pix_t img   [CONV1_CH][N];
    conv1_pix_t img_a [CONV1_CH][N];
    logic [37:0] obs_q[$];
    logic [37:0] exp_q[$];
    int          pcyc_q[$];

    conv1_maxpool_relu dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .conv_in_1      (conv_in_1),
        .conv_in_2      (conv_in_2),
        .conv_in_3      (conv_in_3),
        .pool_out_1     (pool_out_1),
        .pool_out_2     (pool_out_2),
        .pool_out_3     (pool_out_3),
        .valid_out_relu (valid_out_relu),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_out_relu || frame_done) begin
            obs_q.push_back({valid_out_relu, frame_done,
                             pool_out_3, pool_out_2, pool_out_1});
            pcyc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic conv1_pix_t px(input int ch, input int i,
                                      input int add);
        return conv1_pix_t'(int'(img[ch][i]) + add);
    endfunction

    task automatic put(input int i, input int add);
        @(posedge clk); #1;
        valid_in  = 1'b1;
        conv_in_1 = px(0, i, add);
        conv_in_2 = px(1, i, add);
        conv_in_3 = px(2, i, add);
        if (i == CONV1_MAP + 1) acc_cyc = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            valid_in  = 1'b0;
            conv_in_1 = conv1_pix_t'($urandom);
            conv_in_2 = conv1_pix_t'($urandom);
            conv_in_3 = conv1_pix_t'($urandom);
        end
    endtask

    // Values kept in [-2048, 2046] so an image + 1 never wraps.
    task automatic fill();
        for (int ch = 0; ch < CONV1_CH; ch++)
            for (int i = 0; i < N; i++)
                img[ch][i] = conv1_pix_t'(int'($urandom_range(0, 4094)) - 2048);
    endtask

    // Pooled output = ReLU of the max over each 2x2 window.
    task automatic build(input int add);
        for (int pr = 0; pr < POOL1_MAP; pr++) begin
            for (int pc = 0; pc < POOL1_MAP; pc++) begin
                logic [35:0] v;
                v = '0;
                for (int ch = 0; ch < CONV1_CH; ch++) begin
                    int m;
                    m = -100000;
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++) begin
                            int p;
                            p = int'(img[ch][(2*pr+dr)*CONV1_MAP + 2*pc+dc]) + add;
                            if (p > m) m = p;
                        end
                    if (m < 0) m = 0;
                    v[ch*12 +: 12] = 12'(m);
                end
                exp_q.push_back({1'b1, (pr == POOL1_MAP-1 && pc == POOL1_MAP-1), v});
            end
        end
    endtask

    task automatic compare(input string tag, input int n);
        chk($sformatf("%s_count", tag), 64'(obs_q.size()), 64'(n));
        for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
            chk($sformatf("%s_%0d", tag, k), 64'(obs_q[k]), 64'(exp_q[k]));
        obs_q.delete();
        exp_q.delete();
        pcyc_q.delete();
    endtask

    initial begin
        logic [37:0] e;
        logic [37:0] o0, o1, o2;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(valid_out_relu), 64'(0));
        chk("rst_done", 64'(frame_done), 64'(0));
        chk("rst_pool", 64'({pool_out_3, pool_out_2, pool_out_1}), 64'(0));
        rst = 1'b0;
        idle(2);

        // image A: random plus directed windows
        fill();
        img[0][0] = 12'sd5;    img[0][1] = -12'sd3;
        img[0][24] = 12'sd7;   img[0][25] = 12'sd2;
        img[1][0] = -12'sd100; img[1][1] = -12'sd100;
        img[1][24] = -12'sd100; img[1][25] = -12'sd100;
        img[1][2] = -12'sd2048; img[1][3] = -12'sd1;
        img[1][26] = -12'sd5;  img[1][27] = -12'sd7;
        img[1][4] = -12'sd1;   img[1][5] = 12'sd0;
        img[1][28] = -12'sd2;  img[1][29] = -12'sd3;
        img[2][0] = 12'sd2047; img[2][1] = -12'sd2048;
        img[2][24] = 12'sd0;   img[2][25] = 12'sd100;
        img_a = img;
        build(0);
        for (int i = 0; i < N; i++) put(i, 0);
        idle(4);
        chk("latency", 64'(pcyc_q.size() > 0 ? pcyc_q[0] : -1), 64'(acc_cyc));
        o0 = obs_q[0]; o1 = obs_q[1]; o2 = obs_q[2];
        chk("win_max", 64'(o0[11:0]), 64'(7));
        chk("relu_neg100", 64'(o0[23:12]), 64'(0));
        chk("relu_min", 64'(o1[23:12]), 64'(0));
        chk("relu_zero", 64'(o2[23:12]), 64'(0));
        chk("signed_max", 64'(o0[35:24]), 64'(2047));
        e = exp_q[exp_q.size()-1];
        chk("hold_pool", 64'({pool_out_3, pool_out_2, pool_out_1}), 64'(e[35:0]));
        chk("idle_valid", 64'(valid_out_relu), 64'(0));
        compare("cont", 144);

        // full image of -2048
        for (int ch = 0; ch < CONV1_CH; ch++)
            for (int i = 0; i < N; i++) img[ch][i] = -12'sd2048;
        build(0);
        for (int i = 0; i < N; i++) put(i, 0);
        idle(4);
        compare("minimg", 144);

        // throttled replay of image A
        img = img_a;
        build(0);
        for (int i = 0; i < N; i++) begin
            put(i, 0);
            idle((i % 2 == 0) ? 2 : int'($urandom_range(0, 3)));
        end
        idle(4);
        compare("throttle", 144);

        // back-to-back images, second = first + 1
        fill();
        build(0);
        build(1);
        for (int i = 0; i < N; i++) put(i, 0);
        for (int i = 0; i < N; i++) put(i, 1);
        idle(4);
        compare("b2b", 288);

        // reset mid-image, with a pixel presented during reset
        fill();
        for (int i = 0; i < 300; i++) put(i, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        valid_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        valid_in = 1'b0;
        chk("midrst_valid", 64'(valid_out_relu), 64'(0));
        chk("midrst_pool", 64'(pool_out_1), 64'(0));
        chk("midrst_partial", 64'(obs_q.size()), 64'(72));
        obs_q.delete();
        pcyc_q.delete();
        fill();
        build(0);
        for (int i = 0; i < N; i++) put(i, 0);
        idle(4);
        compare("after_rst", 144);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/conv1_maxpool_relu.md
Name: conv1_maxpool_relu

Overview:
- Streaming stage directly downstream of the conv1 calculation stage.
- Consumes the three signed 12-bit conv1 feature-map pixels per valid cycle, in raster order over a 24x24 map per image.
- Applies 2x2 stride-2 max pooling and then ReLU, per channel.
- Emits a 12x12 pooled map per channel to the next stage (conv2 line buffer).

Parameters:
- CONV_BIT, 12, width of each signed conv1 output and pooled output.
- IN_WIDTH, 24, conv1 output map width in pixels (28-5+1).
- IN_HEIGHT, 24, conv1 output map height in rows.
- COL_BIT, 5, width of the column/row counters; must satisfy 2^COL_BIT >= IN_WIDTH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  conv_in_1..3 carry a valid pixel this cycle (driven from valid_out_calc).
- conv_in_1  in  CONV_BIT  signed channel-1 conv pixel.
- conv_in_2  in  CONV_BIT  signed channel-2 conv pixel.
- conv_in_3  in  CONV_BIT  signed channel-3 conv pixel.
- pool_out_1  out  CONV_BIT  signed pooled and ReLU'd channel-1 value.
- pool_out_2  out  CONV_BIT  signed pooled and ReLU'd channel-2 value.
- pool_out_3  out  CONV_BIT  signed pooled and ReLU'd channel-3 value.
- valid_out_relu  out  1  one-cycle pulse; pool_out_1..3 are valid.
- frame_done  out  1  one-cycle pulse, coincident with the 144th valid_out_relu of an image.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: pool_out_1..3 = 0, valid_out_relu = 0, frame_done = 0, col = 0, row = 0, left-pixel registers = 0. Half-row buffer contents are don't-care.
- Counters:
  - col and row advance only on cycles with valid_in = 1. Gaps in valid_in of any length are legal and stall the stage with no state change.
  - col counts 0..IN_WIDTH-1. When col = IN_WIDTH-1 it wraps to 0 and row increments.
  - row counts 0..IN_HEIGHT-1. At row = IN_HEIGHT-1, col = IN_WIDTH-1, both wrap to 0, so the next image starts immediately.
- Per-channel datapath, on each valid_in cycle:
  - col even: store the input in the left register L.
  - col odd: compute P = max(L, input), signed comparison.
  - col odd, row even: write P into the half-row buffer entry H[col>>1]. There are IN_WIDTH/2 entries per channel.
  - col odd, row odd: compute M = max(H[col>>1], P). Register ReLU(M): 0 if M < 0, else M.
  - The registered value appears on pool_out_n with valid_out_relu = 1 in the cycle after the accepting edge. Latency is 1 clock from the 4th (bottom-right) pixel of each 2x2 window.
- Output holding:
  - valid_out_relu is 0 on every other cycle.
  - pool_out_n holds its last value between pulses; it is not cleared.
- Output count: 144 pulses per channel group per image, in raster order of the pooled map.
- frame_done is asserted with the pulse produced from the row = 23, col = 23 input.
- Arithmetic:
  - All comparisons are signed CONV_BIT wide.
  - No widening or saturation is needed; max and ReLU never exceed the input range.
  - -2048 input yields 0 output.
- Boundary conditions:
  - Buffer hazard: an H entry is always written in an even row before it is read in the following odd row. There is no read-before-write hazard and no buffer initialisation is needed.
  - Back-to-back images: row 0 of the next image overwrites H. There are no dead cycles between images.
  - Reset mid-image: counters return to 0 and valid_out_relu drops the next cycle. The next valid_in is treated as pixel (0,0) of a new image, and partial-window data is discarded.
  - rst and valid_in asserted in the same cycle: reset wins and the pixel is dropped.
  - IN_WIDTH and IN_HEIGHT must be even; odd values are unsupported and not checked.

Decomposition:
- Shared package (cnn_pkg):
  - CONV1_OUT_BIT = 12, CONV1_MAP = 24, POOL1_MAP = 12, CONV1_CH = 3.
  - Typedef conv1_pix_t as a signed [11:0] shared with conv1_calc and the conv2 buffer.
- Sub-module maxpool_relu_lane:
  - One channel's L register, H buffer, compare tree, ReLU and output register.
  - Takes col parity, row parity and buffer index from the parent.
  - Instantiated three times under a single shared counter and valid-control block in the parent.

Test Plan:
- Single window: reset, then stream a 24x24 image where channel 1 row 0 cols 0,1 = 5,-3 and row 1 cols 0,1 = 7,2 -> first valid_out_relu exactly 1 clock after the row-1 col-1 edge, pool_out_1 = 7.
- ReLU: channel 2 window all = -100, and a second window = {-2048, -1, -5, -7} -> pool_out_2 = 0 for both; a window {-1, 0, -2, -3} -> 0.
- Signed max / extremes: window {2047, -2048, 0, 100} -> 2047; full image of -2048 -> 144 outputs, all 0.
- Throttled input: the same image sent with valid_in toggling 1,0,0,1,... and random gaps -> output values and order identical to the continuous run, with exactly 144 pulses and frame_done on the 144th.
- Back-to-back images: stream two 576-pixel images with no gap (image 2 = image 1 + 1) -> 288 pulses, second set equals ReLU(golden + 1), and frame_done pulses twice.
- Reset mid-image: assert rst after 300 input pixels, then stream a full image -> no pulse in the cycle after rst, then exactly 144 pulses matching the golden model for the new image only.
